// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE control sequencer for a 16-bit instruction set.
// Define IMEM_TIMEOUT_EN to halt with fault when a fetch is not acknowledged within TIMEOUT_CYC cycles.
module control_sequencer #(
    parameter int PC_W        = 8,  // must not exceed 16: branch targets come from ir[PC_W-1:0]
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [2:0]      rs,
    output logic [2:0]      rt,
    output logic [2:0]      rd,
    output logic [2:0]      alu_op,
    output logic [5:0]      immidiate,
    output logic            select_imm,
    output logic            reg_write,
    input  logic            carry,
    input  logic            overflow,
    input  logic            zero,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [2:0]      flags;  // {carry, overflow, zero}
    logic            alu_class;
    logic            halt_instr;
    logic            cond_met;
    logic            branch_taken;
    logic            fetch_timeout;

    assign alu_class    = ~ir[15];
    assign halt_instr   = (ir[15:14] == 2'b11) && ir[13];
    assign branch_taken = (ir[15:14] == 2'b10) && cond_met;

    assign alu_op     = ir[13:11];
    assign rd         = ir[10:8];
    assign rs         = ir[7:5];
    assign rt         = ir[4:2];
    assign immidiate  = ir[5:0];
    assign select_imm = (ir[15:14] == 2'b01);
    assign imem_addr  = pc;

    always_comb begin
        cond_met = 1'b0;
        case (ir[13:12])
            2'b00: cond_met = 1'b1;
            2'b01: cond_met = flags[0];
            2'b10: cond_met = flags[2];
            2'b11: cond_met = flags[1];
            default: cond_met = 1'b0;
        endcase
    end

`ifdef IMEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign fetch_timeout = (state == FETCH) && !imem_ack &&
                           (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else if (state == FETCH) begin
            if (imem_ack)
                wait_cnt <= '0;
            else if (fetch_timeout)
                fault <= 1'b1;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end else if (state == EXECUTE) begin
            wait_cnt <= '0;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign fetch_timeout = 1'b0;
    assign fault         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                // State already reads FETCH while reset is held; keep the bus quiet until release.
                imem_req = rst_n;
                if (imem_ack)
                    state_next = DECODE;
                else if (fetch_timeout)
                    state_next = HALT;
            end
            DECODE:  state_next = EXECUTE;
            EXECUTE: begin
                reg_write  = alu_class;
                state_next = halt_instr ? HALT : FETCH;
            end
            HALT:    halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values,
    // which is what lets a branch test the flags as they stood before this EXECUTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
        end else begin
            if (state == FETCH && imem_ack)
                ir <= imem_data;
            if (state == EXECUTE) begin
                if (alu_class)
                    flags <= {carry, overflow, zero};
                pc <= branch_taken ? ir[PC_W-1:0] : pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a scoreboard of expected fetch addresses is
// filled by each scenario and drained as the sequencer issues fetches.
module tb_control_sequencer;

    localparam int PC_W = 8;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b1;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack  = 1'b0;
    logic [15:0]     imem_data = '0;
    logic [2:0]      rs, rt, rd, alu_op;
    logic [5:0]      immidiate;
    logic            select_imm, reg_write;
    logic            carry = 1'b0, overflow = 1'b0, zero = 1'b0;
    logic            halted, fault;

    int tests = 0;
    int fails = 0;
    logic [PC_W-1:0] exp_addr[$];

    control_sequencer #(.PC_W(PC_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .immidiate(immidiate),
        .select_imm(select_imm), .reg_write(reg_write),
        .carry(carry), .overflow(overflow), .zero(zero),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        {carry, overflow, zero} = 3'b000;
        exp_addr.delete();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Serves one fetch (after 'delay' wait cycles), then follows DECODE and EXECUTE.
    task automatic do_instr(input logic [15:0] instr, input int delay, input logic exp_wr,
                            input logic [2:0] cvz, input string name);
        logic [PC_W-1:0] exp_a;
        logic [PC_W-1:0] held;
        {carry, overflow, zero} = cvz;
        tests++;
        if (exp_addr.size() == 0) begin
            fails++;
            $display("FAIL %s fetch: addr=%0h issued, scoreboard held no expected address", name, imem_addr);
        end else begin
            exp_a = exp_addr.pop_front();
            if (imem_req !== 1'b1 || imem_addr !== exp_a || reg_write !== 1'b0) begin
                fails++;
                $display("FAIL %s fetch: req=%b addr=%0h wr=%b, required req=1 addr=%0h wr=0",
                         name, imem_req, imem_addr, reg_write, exp_a);
            end
        end
        held     = imem_addr;
        imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== held || reg_write !== 1'b0) begin
                fails++;
                $display("FAIL %s wait%0d: req=%b addr=%0h wr=%b, required req=1 addr=%0h wr=0",
                         name, i, imem_req, imem_addr, reg_write, held);
            end
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        tick();
        // Stray ack with a different word during DECODE/EXECUTE must be ignored.
        imem_data = ~instr;
        tests++;
        if (imem_req !== 1'b0 || reg_write !== 1'b0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL %s decode: req=%b wr=%b halted=%b, required 0 0 0",
                     name, imem_req, reg_write, halted);
        end
        tick();
        tests++;
        if (imem_req !== 1'b0 || reg_write !== exp_wr) begin
            fails++;
            $display("FAIL %s execute: req=%b wr=%b, required req=0 wr=%b",
                     name, imem_req, reg_write, exp_wr);
        end
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #2;
        tests++;
        if ({imem_req, reg_write, halted, fault} !== 4'b0000 || imem_addr !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: req=%b wr=%b halted=%b fault=%b addr=%0h, required all 0",
                     imem_req, reg_write, halted, fault, imem_addr);
        end
        tests++;
        if ({alu_op, rd, rs, rt} !== 12'h000 || immidiate !== 6'h00 || select_imm !== 1'b0) begin
            fails++;
            $display("FAIL reset_ir: alu_op=%0d rd=%0d rs=%0d rt=%0d imm=%0h sel=%b, required all 0",
                     alu_op, rd, rs, rt, immidiate, select_imm);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            fails++;
            $display("FAIL first_fetch: req=%b addr=%0h, required req=1 addr=0", imem_req, imem_addr);
        end
        exp_addr.push_back(8'h00);
        do_instr(16'h0000, 0, 1'b1, 3'b001, "rst_alu_zero");
        // Sequencer now waits at addr 1; reset it asynchronously between edges.
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== 8'h00 || reg_write !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: req=%b addr=%0h wr=%b, required req=0 addr=0 wr=0",
                     imem_req, imem_addr, reg_write);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        // Flags were cleared, so a zero-conditional branch falls through despite zero=1 at the input.
        exp_addr.push_back(8'h00);
        do_instr(16'h9040, 0, 1'b0, 3'b001, "rst_flags_cleared");
        exp_addr.push_back(8'h01);
        do_instr(16'hC000, 0, 1'b0, 3'b000, "rst_after_branch");
    endtask

    task automatic test_sequential();
        apply_reset();
        for (int i = 0; i < 258; i++) begin
            exp_addr.push_back(PC_W'(i));
            do_instr(16'h0000, 0, 1'b1, 3'b000, "seq_wrap");
        end
    endtask

    task automatic test_itype();
        apply_reset();
        exp_addr.push_back(8'h00);
        do_instr(16'h4A45, 0, 1'b1, 3'b000, "itype");
        tests++;
        if (select_imm !== 1'b1 || immidiate !== 6'h05 || alu_op !== 3'd1 ||
            rd !== 3'd2 || rs !== 3'd2 || rt !== 3'd1) begin
            fails++;
            $display("FAIL itype_fields: sel=%b imm=%0h op=%0d rd=%0d rs=%0d rt=%0d, required 1 05 1 2 2 1",
                     select_imm, immidiate, alu_op, rd, rs, rt);
        end
        exp_addr.push_back(8'h01);
        do_instr(16'h3B9C, 0, 1'b1, 3'b000, "rtype");
        tests++;
        if (select_imm !== 1'b0 || alu_op !== 3'd7 || rd !== 3'd3 || rs !== 3'd4 || rt !== 3'd7) begin
            fails++;
            $display("FAIL rtype_fields: sel=%b op=%0d rd=%0d rs=%0d rt=%0d, required 0 7 3 4 7",
                     select_imm, alu_op, rd, rs, rt);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        exp_addr.push_back(8'h00); do_instr(16'h0000, 0, 1'b1, 3'b001, "br_alu_zero1");
        exp_addr.push_back(8'h01); do_instr(16'hC000, 0, 1'b0, 3'b000, "br_nop_keeps_flags");
        exp_addr.push_back(8'h02); do_instr(16'h9040, 0, 1'b0, 3'b000, "br_zero_taken");
        exp_addr.push_back(8'h40); do_instr(16'h0000, 0, 1'b1, 3'b000, "br_alu_zero0");
        exp_addr.push_back(8'h41); do_instr(16'h9040, 0, 1'b0, 3'b001, "br_zero_not_taken");
        exp_addr.push_back(8'h42); do_instr(16'h8010, 0, 1'b0, 3'b000, "br_always");
        exp_addr.push_back(8'h10); do_instr(16'h0000, 0, 1'b1, 3'b100, "br_alu_carry");
        exp_addr.push_back(8'h11); do_instr(16'hA055, 0, 1'b0, 3'b000, "br_carry_taken");
        exp_addr.push_back(8'h55); do_instr(16'hB077, 0, 1'b0, 3'b010, "br_ovf_not_taken");
        exp_addr.push_back(8'h56); do_instr(16'h4000, 0, 1'b1, 3'b010, "br_alu_ovf");
        exp_addr.push_back(8'h57); do_instr(16'hB0FF, 0, 1'b0, 3'b000, "br_ovf_taken");
        exp_addr.push_back(8'hFF); do_instr(16'h0000, 0, 1'b1, 3'b000, "br_at_top");
        exp_addr.push_back(8'h00); do_instr(16'hC000, 0, 1'b0, 3'b000, "br_wrapped");
    endtask

    task automatic test_fetch_wait();
        apply_reset();
        exp_addr.push_back(8'h00); do_instr(16'h4A45, 5, 1'b1, 3'b000, "wait5");
        exp_addr.push_back(8'h01); do_instr(16'h0000, 3, 1'b1, 3'b000, "wait3");
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(PC_W'(i + 2));
            do_instr(16'hC000, int'($urandom_range(0, 4)), 1'b0, 3'b000, "wait_rand");
        end
    endtask

    task automatic test_halt();
        int bad;
        apply_reset();
        exp_addr.push_back(8'h00); do_instr(16'h0000, 0, 1'b1, 3'b000, "pre_halt");
        exp_addr.push_back(8'h01); do_instr(16'hE000, 0, 1'b0, 3'b000, "halt");
        tests++;
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL halt_entry: halted=%b req=%b, required halted=1 req=0", halted, imem_req);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack  = 1'b1;
            imem_data = 16'($urandom);
            tick();
            if (halted !== 1'b1 || imem_req !== 1'b0 || reg_write !== 1'b0) bad++;
        end
        imem_ack = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_sticky: %0d of 20 cycles left HALT behaviour, required 0", bad);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (halted !== 1'b0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: halted=%b req=%b, required 0 0", halted, imem_req);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        exp_addr.push_back(8'h00); do_instr(16'h0000, 0, 1'b1, 3'b000, "resume");
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
`ifdef IMEM_TIMEOUT_EN
        repeat (15) tick();
        tests++;
        if (fault !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: fault=%b halted=%b req=%b, required 0 0 1", fault, halted, imem_req);
        end
        tick();
        tests++;
        if (fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_fire: fault=%b halted=%b req=%b, required 1 1 0", fault, halted, imem_req);
        end
        apply_reset();
        exp_addr.push_back(8'h00); do_instr(16'hC000, 15, 1'b0, 3'b000, "to_wait15_a");
        exp_addr.push_back(8'h01); do_instr(16'hC000, 15, 1'b0, 3'b000, "to_wait15_b");
        tests++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            fault_msg: $display("FAIL timeout_clear: fault=%b halted=%b, required 0 0", fault, halted);
            fails++;
        end
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || halted !== 1'b0 ||
                fault !== 1'b0 || reg_write !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_timeout: %0d of 100 cycles left FETCH at addr 0, required 0", bad);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_itype();
        test_branch();
        test_fetch_wait();
        test_halt();
        test_timeout();
        tests++;
        if (exp_addr.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected fetches never issued, required 0", exp_addr.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program counter and instruction address width.
REQ-002 Parameter TIMEOUT_CYC, default 16, fetch-acknowledge limit used only under IMEM_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  PC_W  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch acknowledge; imem_data is valid in the same cycle.
REQ-008 imem_data  input  16  instruction word.
REQ-009 rs, rt, rd  output  3 each  register selects to the datapath.
REQ-010 alu_op  output  3  ALU operation to the datapath.
REQ-011 immidiate  output  6  immediate field to the datapath.
REQ-012 select_imm  output  1  1 selects the immediate as ALU operand B.
REQ-013 reg_write  output  1  register-file write enable.
REQ-014 carry, overflow, zero  input  1 each  ALU flags from the datapath.
REQ-015 halted  output  1  high in HALT state.
REQ-016 fault  output  1  fetch timeout indication.

Function
REQ-017 Instruction fields: ir[15:14] class, with 00=R, 01=I, 10=branch, 11=system.
REQ-018 R/I fields: alu_op=ir[13:11], rd=ir[10:8], rs=ir[7:5], rt=ir[4:2], immidiate=ir[5:0].
REQ-019 Control outputs decode continuously from the instruction register (ir); select_imm=1 only for class 01.
REQ-020 FSM states: FETCH, DECODE, EXECUTE, HALT.
REQ-021 FETCH: imem_req=1 and imem_addr=pc held stable until imem_ack=1; on ack, ir<=imem_data and next state is DECODE.
REQ-022 DECODE: lasts one cycle with reg_write=0 so datapath operands settle; next state is EXECUTE.
REQ-023 EXECUTE: lasts one cycle; reg_write=1 only for class 00/01; next state is FETCH, or HALT for class 11 with ir[13]=1.
REQ-024 Flag register: on EXECUTE of a class 00/01 instruction, flag register <= {carry, overflow, zero}; other instructions leave it unchanged.
REQ-025 Branch (class 10): ir[13:12] condition, with 00=always, 01=zero flag, 10=carry flag, 11=overflow flag; target=ir[PC_W-1:0].
REQ-026 Branch conditions use the flag register as it stood before this EXECUTE.
REQ-027 PC update at the end of EXECUTE: taken branch sets pc<=target; all other cases set pc<=pc+1, modulo 2^PC_W (255 wraps to 0).
REQ-028 System class with ir[13]=0 is NOP: no write, no flag change.
REQ-029 Latency is 3 cycles per instruction when imem_ack is returned in the first FETCH cycle, plus one cycle per fetch wait cycle.
REQ-030 HALT: imem_req=0, reg_write=0, halted=1; the block leaves HALT only by reset.
REQ-031 imem_ack outside FETCH is ignored.
REQ-032 reg_write is never high outside EXECUTE.

Reset
REQ-033 rst_n low, at any time including mid-fetch: pc=0, ir=16'h0000, flags=0, state=FETCH, fault=0, halted=0.
REQ-034 While rst_n is low, imem_req=0 and reg_write=0.
REQ-035 After rst_n rises, the first fetch is from address 0 on the first clock edge.

Configuration
REQ-036 Macro IMEM_TIMEOUT_EN defined: a wait counter counts FETCH cycles without ack; reaching TIMEOUT_CYC enters HALT with fault=1.
REQ-037 Under IMEM_TIMEOUT_EN, the wait counter clears on ack and on each new FETCH.
REQ-038 Macro IMEM_TIMEOUT_EN undefined: FETCH waits indefinitely, fault is tied 0, and no wait counter exists.

Verification
REQ-039 Reset, then ack every fetch with 16'h0000 -> imem_addr sequence 0,1,2,...; reg_write pulses once every 3 cycles; addr 255 followed by addr 0.
REQ-040 Instruction 16'h4A45 (I-type, alu_op=001, rd=2, rs=2, imm=6'h05) -> select_imm=1, immidiate=6'h05, one reg_write pulse.
REQ-041 ALU op returns zero=1, then branch 16'h9040 (cond zero, target 8'h40) -> next imem_addr=8'h40; with zero=0 -> pc+1.
REQ-042 Delay imem_ack 5 cycles -> imem_req and imem_addr held stable throughout; instruction completes 5 cycles later; no reg_write during the wait.
REQ-043 Instruction 16'hE000 (HALT) -> halted=1, imem_req=0 permanently; stray imem_ack is ignored; rst_n pulse resumes execution at addr 0.
REQ-044 With IMEM_TIMEOUT_EN, no ack for 16 cycles -> fault=1 and halted=1; without the macro, the block is still in FETCH after 100 cycles.
